alu_issue_ctrl: RTL and testbench

- Command-side initiator for the 16-bit combinational ALU (ADD/SUB/AND/XOR/SHL/SHR, 4-bit control).
- Accepts 16-bit instruction words over a valid/ready port and holds an 8x16 register file.
- For each instruction it drives ALU operands and control, captures the ALU result, writes it back, and returns a response over a second valid/ready port.
- Sits between a command source (test sequencer or host bus) and one alu instance.

---
 rtl/alu_issue_pkg.sv | 32 +++
 rtl/alu_issue_regfile.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction field layout, FSM states.
// Holds no logic of its own.
package alu_issue_pkg;

  localparam int DATA_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_LDI = 4'b1000;

  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int REG_W   = 3;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 9;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // ALU opcodes occupy a contiguous range starting at zero
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_SHR;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one synchronous write port.
// Read latency 0 cycles, write visible after the clock edge.
// No backpressure; a write is accepted on every cycle we is high.
module alu_issue_regfile #(
  parameter int NREGS = 8,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] RF_RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [DATA_W-1:0]        rdata1,
  output logic [DATA_W-1:0]        rdata2
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= RF_RST_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues instructions to an external combinational ALU, writes results back, returns a response.
// Latency: accept at edge T, response valid after edge T+1; 3 cycles per instruction minimum.
// Backpressure: one instruction in flight; cmd_ready stays low until the response handshakes.
module alu_issue_ctrl #(
  parameter int DATA_W = alu_issue_pkg::DATA_W,
  parameter int NREGS = 8,
  parameter logic [DATA_W-1:0] RF_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_instr,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_rd,
  output logic              rsp_err
);
  import alu_issue_pkg::*;

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   res_q;
  logic                err_q;

  logic [OPC_W-1:0]    opcode;
  logic [REG_W-1:0]    rd, rs1, rs2;
  logic [IMM_W-1:0]    imm9;
  logic [DATA_W-1:0]   imm_ext, rs1_val, rs2_val, rf_wdata;
  logic                is_alu, is_ldi, rf_we;

  assign opcode  = instr_q[OPC_LSB +: OPC_W];
  assign rd      = instr_q[RD_LSB  +: REG_W];
  assign rs1     = instr_q[RS1_LSB +: REG_W];
  assign rs2     = instr_q[RS2_LSB +: REG_W];
  assign imm9    = instr_q[IMM_LSB +: IMM_W];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm9};
  assign is_alu  = is_alu_op(opcode);
  assign is_ldi  = (opcode == OP_LDI);

  // Writeback lands on the edge that ends EXEC, so the next EXEC already sees it
  assign rf_we    = (state_q == EXEC) && (is_alu || is_ldi);
  assign rf_wdata = is_ldi ? imm_ext : alu_result;

  alu_issue_regfile #(
    .NREGS      (NREGS),
    .DATA_W     (DATA_W),
    .RF_RST_VAL (RF_RST_VAL)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_ctrl  = 4'b0000;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted even though the state already reads IDLE
        cmd_ready = rst_n;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: begin
        alu_op1  = rs1_val;
        alu_op2  = rs2_val;
        alu_ctrl = opcode;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) instr_q <= cmd_instr;
      if (state_q == EXEC) begin
        res_q <= rf_we ? rf_wdata : '0;
        err_q <= !rf_we;
      end
    end
  end

  assign rsp_data = res_q;
  assign rsp_rd   = rd;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: drives a behavioural ALU, directed scenarios and randomized traffic
// checked against a register-array reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_instr;
  logic [15:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] mrf [8];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  // Stand-in for the external combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'h0: alu_result = alu_op1 + alu_op2;
      4'h1: alu_result = alu_op1 - alu_op2;
      4'h2: alu_result = alu_op1 & alu_op2;
      4'h3: alu_result = alu_op1 ^ alu_op2;
      4'h4: alu_result = alu_op1 << alu_op2;
      4'h5: alu_result = alu_op1 >> alu_op2;
      default: alu_result = '0;
    endcase
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input int rd, input int rs1, input int rs2);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'h8, 3'(rd), 9'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
  endtask

  // Architectural effect of one instruction, from plain integer arithmetic
  task automatic model(input logic [15:0] ins, output logic [15:0] d, output logic e);
    longint a, b, r;
    a = mrf[ins[8:6]];
    b = mrf[ins[5:3]];
    e = 1'b0;
    r = 0;
    case (ins[15:12])
      4'h0: r = (a + b) % 65536;
      4'h1: r = (a - b + 65536) % 65536;
      4'h2: r = a & b;
      4'h3: r = a ^ b;
      4'h4: r = (b >= 16) ? 0 : (a * (longint'(1) << b)) % 65536;
      4'h5: r = (b >= 16) ? 0 : a / (longint'(1) << b);
      4'h8: r = ins[8:0];
      default: e = 1'b1;
    endcase
    d = 16'(r);
    if (!e) mrf[ins[11:9]] = d;
  endtask

  // Runs one instruction; hold>0 keeps rsp_ready low for that many cycles once the response shows
  task automatic issue(input logic [15:0] ins, input int hold,
                       output logic [15:0] d, output logic [2:0] rd, output logic e,
                       output int lat, output logic [15:0] x1, output logic [15:0] x2,
                       output logic [3:0] xc, output logic ok, output logic stable);
    int n;
    ok = 1'b1; stable = 1'b1; lat = 0;
    d = '0; rd = '0; e = 1'b0; x1 = '0; x2 = '0; xc = '0;
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_instr = ins;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin ok = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; return; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_instr = 16'($urandom);
    x1 = alu_op1; x2 = alu_op2; xc = alu_ctrl;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin ok = 1'b0; rsp_ready = 1'b1; return; end
    d = rsp_data; rd = rsp_rd; e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_rd !== rd || rsp_err !== e || cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_instr = '0; rsp_ready = 1'b1;
    model_reset();
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %0b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if ({rsp_data, rsp_rd, rsp_err} !== 20'h0) begin errors++; $display("FAIL reset_rsp got %h/%0d/%0b want 0", rsp_data, rsp_rd, rsp_err); end
    checks++; if ({alu_op1, alu_op2, alu_ctrl} !== 36'h0) begin errors++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_op1, alu_op2, alu_ctrl); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %0b want 1", cmd_ready); end
  endtask

  task automatic test_load_add();
    logic [15:0] prog [3];
    logic [15:0] exp_d [3];
    logic [15:0] d, x1, x2, md;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st;
    int lat;
    prog  = '{ldi(1, 5), ldi(2, 3), mk(4'h0, 3, 1, 2)};
    exp_d = '{16'd5, 16'd3, 16'd8};
    for (int i = 0; i < 3; i++) begin
      model(prog[i], md, me);
      issue(prog[i], 0, d, rd, e, lat, x1, x2, xc, ok, st);
      checks++; if (!ok) begin errors++; $display("FAIL load_add_timeout step %0d got timeout want response", i); end
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL load_add_data step %0d got %h want %h", i, d, exp_d[i]); end
      checks++; if (rd !== 3'(i + 1)) begin errors++; $display("FAIL load_add_rd step %0d got %0d want %0d", i, rd, i + 1); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL load_add_err step %0d got %0b want 0", i, e); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL load_add_latency step %0d got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_sub_xor();
    logic [15:0] d, x1, x2, md;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st;
    int lat;
    model(mk(4'h1, 4, 2, 1), md, me);
    issue(mk(4'h1, 4, 2, 1), 0, d, rd, e, lat, x1, x2, xc, ok, st);
    checks++; if (d !== 16'hFFFE || !ok) begin errors++; $display("FAIL sub_wrap got %h want fffe", d); end
    checks++; if (x1 !== 16'd3 || x2 !== 16'd5 || xc !== 4'h1) begin errors++; $display("FAIL sub_alu_drive got %h/%h/%h want 0003/0005/1", x1, x2, xc); end
    model(mk(4'h3, 4, 4, 4), md, me);
    issue(mk(4'h3, 4, 4, 4), 0, d, rd, e, lat, x1, x2, xc, ok, st);
    checks++; if (d !== 16'h0000 || rd !== 3'd4 || !ok) begin errors++; $display("FAIL xor_self got %h rd %0d want 0000 rd 4", d, rd); end
    checks++; if (x1 !== 16'hFFFE || x2 !== 16'hFFFE) begin errors++; $display("FAIL xor_old_operands got %h/%h want fffe/fffe", x1, x2); end
  endtask

  task automatic test_shifts();
    logic [15:0] prog [4];
    logic [15:0] exp_d [4];
    logic [15:0] d, x1, x2, md;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st;
    int lat;
    prog  = '{ldi(6, 16), mk(4'h4, 5, 1, 2), mk(4'h5, 5, 5, 2), mk(4'h4, 7, 1, 6)};
    exp_d = '{16'd16, 16'd40, 16'd5, 16'd0};
    for (int i = 0; i < 4; i++) begin
      model(prog[i], md, me);
      issue(prog[i], 0, d, rd, e, lat, x1, x2, xc, ok, st);
      checks++; if (d !== exp_d[i] || e !== 1'b0 || !ok) begin errors++; $display("FAIL shift step %0d got %h err %0b want %h err 0", i, d, e, exp_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d, x1, x2, md;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st, extra;
    int lat;
    model(mk(4'h0, 3, 1, 2), md, me);
    issue(mk(4'h0, 3, 1, 2), 5, d, rd, e, lat, x1, x2, xc, ok, st);
    checks++; if (st !== 1'b1 || !ok) begin errors++; $display("FAIL backpressure_stable got %0b want 1", st); end
    checks++; if (d !== 16'd8) begin errors++; $display("FAIL backpressure_data got %h want 0008", d); end
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release got valid %0b ready %0b want 0/1", rsp_valid, cmd_ready); end
    extra = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (rsp_valid) extra = 1'b1; end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL backpressure_single got extra response want none"); end
  endtask

  task automatic test_illegal();
    logic [15:0] d, x1, x2, md;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st;
    int lat;
    model(mk(4'h7, 1, 1, 2), md, me);
    issue(mk(4'h7, 1, 1, 2), 0, d, rd, e, lat, x1, x2, xc, ok, st);
    checks++; if (e !== 1'b1 || d !== 16'h0000 || !ok) begin errors++; $display("FAIL illegal_rsp got err %0b data %h want err 1 data 0000", e, d); end
    checks++; if (rd !== 3'd1) begin errors++; $display("FAIL illegal_rd got %0d want 1", rd); end
    model(mk(4'h0, 3, 1, 2), md, me);
    issue(mk(4'h0, 3, 1, 2), 0, d, rd, e, lat, x1, x2, xc, ok, st);
    checks++; if (d !== 16'd8 || e !== 1'b0) begin errors++; $display("FAIL illegal_no_write got %h want 0008", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    logic [15:0] exp_d [3];
    logic [15:0] d, x1, x2, md;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st;
    int lat;
    prog  = '{ldi(0, 7), mk(4'h0, 0, 0, 0), mk(4'h0, 0, 0, 0)};
    exp_d = '{16'd7, 16'd14, 16'd28};
    for (int i = 0; i < 3; i++) begin
      model(prog[i], md, me);
      issue(prog[i], 0, d, rd, e, lat, x1, x2, xc, ok, st);
      checks++; if (d !== exp_d[i] || !ok) begin errors++; $display("FAIL b2b_data step %0d got %h want %h", i, d, exp_d[i]); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready step %0d got %0b want 1", i, cmd_ready); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ins, d, x1, x2, md, e1, e2;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st;
    int lat, sel, hold;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) ins = mk(4'(sel), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else if (sel <= 7) ins = {4'h8, 12'($urandom)};
      else ins = {4'($urandom_range(6, 15)), 12'($urandom)};
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      e1 = mrf[ins[8:6]];
      e2 = mrf[ins[5:3]];
      model(ins, md, me);
      issue(ins, hold, d, rd, e, lat, x1, x2, xc, ok, st);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout iter %0d instr %h", i, ins); end
      checks++; if (d !== md || e !== me || rd !== ins[11:9]) begin errors++; $display("FAIL rand_rsp iter %0d instr %h got %h/%0b/%0d want %h/%0b/%0d", i, ins, d, e, rd, md, me, ins[11:9]); end
      checks++; if (x1 !== e1 || x2 !== e2 || xc !== ins[15:12]) begin errors++; $display("FAIL rand_alu_drive iter %0d got %h/%h/%h want %h/%h/%h", i, x1, x2, xc, e1, e2, ins[15:12]); end
      checks++; if (lat !== 2 || st !== 1'b1) begin errors++; $display("FAIL rand_timing iter %0d got lat %0d stable %0b want 2/1", i, lat, st); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d, x1, x2, md;
    logic [2:0] rd;
    logic [3:0] xc;
    logic e, me, ok, st, seen;
    int lat, n;
    model(ldi(1, 9), md, me);
    issue(ldi(1, 9), 0, d, rd, e, lat, x1, x2, xc, ok, st);
    cmd_valid = 1'b1;
    cmd_instr = mk(4'h0, 3, 1, 1);
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (alu_op1 !== 16'd9 || alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_mid_exec got op1 %h want 0009", alu_op1); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_outputs got valid %0b ready %0b want 0/0", rsp_valid, cmd_ready); end
    checks++; if (alu_op1 !== 16'h0 || alu_op2 !== 16'h0) begin errors++; $display("FAIL reset_mid_alu got %h/%h want 0/0", alu_op1, alu_op2); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_discard got response want none"); end
    model(mk(4'h0, 3, 1, 2), md, me);
    issue(mk(4'h0, 3, 1, 2), 0, d, rd, e, lat, x1, x2, xc, ok, st);
    checks++; if (d !== 16'h0000 || d !== md || !ok) begin errors++; $display("FAIL reset_mid_regs got %h want 0000", d); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_sub_xor();
    test_shifts();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
